// File: rtl/pll_lock_sequencer_if.sv
// Signal bundle between the PLL lock sequencer and its surroundings.
// The slave side is the sequencer. The master side is whatever drives locked_async.
interface pll_lock_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             locked_async;
  logic             pll_rst;
  logic             sys_rst;
  logic             ready;
  logic             lock_lost;
  logic             timeout;
  logic [CNT_W-1:0] loss_count;

  modport master (
    output locked_async,
    input  pll_rst, sys_rst, ready, lock_lost, timeout, loss_count
  );

  modport slave (
    input  locked_async,
    output pll_rst, sys_rst, ready, lock_lost, timeout, loss_count
  );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Qualifies the PLL lock signal, then sequences the PLL reset and the downstream system reset.
// It re-resets the PLL on an acquire timeout or on loss of lock, and counts lock-loss events.
module pll_lock_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int STABLE_CYCLES  = 1024,
  parameter int RST_HOLD       = 16,
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int PLLRST_CYCLES  = 8,
  parameter int CNT_W          = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  pll_lock_sequencer_if.slave  bus
);

  // Only one phase is timed at a time, so every state shares one phase counter.
  localparam int MAX_SR  = (STABLE_CYCLES > RST_HOLD) ? STABLE_CYCLES : RST_HOLD;
  localparam int MAX_TP  = (TIMEOUT_CYCLES > PLLRST_CYCLES) ? TIMEOUT_CYCLES : PLLRST_CYCLES;
  localparam int CNT_MAX = (MAX_SR > MAX_TP) ? MAX_SR : MAX_TP;
  localparam int TW      = $clog2(CNT_MAX) + 1;

  localparam logic [TW-1:0] C_PLLRST_LAST  = TW'(PLLRST_CYCLES - 1);
  localparam logic [TW-1:0] C_TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] C_STABLE_LAST  = TW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] C_HOLD_LAST    = TW'(RST_HOLD - 1);

  typedef enum logic [2:0] {
    S_RESET_PLL,
    S_WAIT_LOCK,
    S_STABLE,
    S_HOLD,
    S_RUN
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_locked_s;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [TW-1:0]          r_cnt;
  logic [TW-1:0]          w_cnt_nxt;
  logic [CNT_W-1:0]       r_loss_count;
  logic [CNT_W-1:0]       w_loss_count_nxt;
  logic                   w_timeout_nxt;
  logic                   w_lost_nxt;

  logic                   r_pll_rst;
  logic                   r_sys_rst;
  logic                   r_ready;
  logic                   r_lock_lost;
  logic                   r_timeout;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.locked_async};
    end
  end

  assign w_locked_s = r_sync[SYNC_STAGES-1];

  // NOTE: every variable gets a default first so no path through the case infers a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_loss_count_nxt = r_loss_count;
    w_timeout_nxt    = 1'b0;
    w_lost_nxt       = 1'b0;

    unique case (r_state)
      S_RESET_PLL: begin
        if (r_cnt == C_PLLRST_LAST) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + TW'(1);
        end
      end

      // Lock is checked before expiry, so a lock that arrives on the last cycle wins.
      S_WAIT_LOCK: begin
        if (w_locked_s) begin
          w_state_nxt = S_STABLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_TIMEOUT_LAST) begin
          w_state_nxt   = S_RESET_PLL;
          w_cnt_nxt     = '0;
          w_timeout_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + TW'(1);
        end
      end

      S_STABLE: begin
        if (!w_locked_s) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_STABLE_LAST) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + TW'(1);
        end
      end

      S_HOLD: begin
        if (!w_locked_s) begin
          w_state_nxt = S_WAIT_LOCK;
          w_cnt_nxt   = '0;
        end else if (r_cnt == C_HOLD_LAST) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + TW'(1);
        end
      end

      S_RUN: begin
        if (!w_locked_s) begin
          w_state_nxt = S_RESET_PLL;
          w_cnt_nxt   = '0;
          w_lost_nxt  = 1'b1;
          if (r_loss_count != '1) begin
            w_loss_count_nxt = r_loss_count + CNT_W'(1);
          end
        end
      end

      default: begin
        w_state_nxt = S_RESET_PLL;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state, so they are registered and aligned with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_RESET_PLL;
      r_cnt        <= '0;
      r_loss_count <= '0;
      r_pll_rst    <= 1'b1;
      r_sys_rst    <= 1'b1;
      r_ready      <= 1'b0;
      r_lock_lost  <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_loss_count <= w_loss_count_nxt;
      r_pll_rst    <= (w_state_nxt == S_RESET_PLL);
      r_sys_rst    <= (w_state_nxt != S_RUN);
      r_ready      <= (w_state_nxt == S_RUN);
      r_lock_lost  <= w_lost_nxt;
      r_timeout    <= w_timeout_nxt;
    end
  end

  assign bus.pll_rst    = r_pll_rst;
  assign bus.sys_rst    = r_sys_rst;
  assign bus.ready      = r_ready;
  assign bus.lock_lost  = r_lock_lost;
  assign bus.timeout    = r_timeout;
  assign bus.loss_count = r_loss_count;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with an event-cycle scoreboard.
// The expected cycle of each DUT event is queued when its stimulus is driven.
module tb_pll_lock_sequencer;

  localparam int CNT_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_timeout = 0;
  int   n_both = 0;
  int   e0 = 0;
  int   exp_q[$];

  pll_lock_sequencer_if #(.CNT_W(CNT_W)) bus ();

  pll_lock_sequencer #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (8),
    .RST_HOLD      (4),
    .TIMEOUT_CYCLES(64),
    .PLLRST_CYCLES (3),
    .CNT_W         (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.timeout) n_timeout <= n_timeout + 1;
    if (bus.timeout && bus.lock_lost) n_both <= n_both + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // sel 0: sys_rst low, 1: timeout high, 2: lock_lost high. Returns -1 if the budget runs out.
  task automatic wait_for(input int sel, input int budget, output int at);
    logic hit;
    at = -1;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      case (sel)
        0:       hit = (bus.sys_rst === 1'b0);
        1:       hit = (bus.timeout === 1'b1);
        default: hit = (bus.lock_lost === 1'b1);
      endcase
      if (hit) begin
        at = cyc;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    bus.locked_async = 1'b0;
    tick(2);
    rst = 1'b0;
    e0 = cyc;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pll_rst"},    bus.pll_rst,    1);
    check({tag, "_sys_rst"},    bus.sys_rst,    1);
    check({tag, "_ready"},      bus.ready,      0);
    check({tag, "_lock_lost"},  bus.lock_lost,  0);
    check({tag, "_timeout"},    bus.timeout,    0);
    check({tag, "_loss_count"}, bus.loss_count, 0);
  endtask

  task automatic lose_lock(input int exp_count);
    int d;
    int at;
    tick(2);
    d = cyc;
    bus.locked_async = 1'b0;
    exp_q.push_back(d + 3);
    exp_q.push_back(d + 19);
    tick(1);
    bus.locked_async = 1'b1;
    wait_for(2, 20, at);
    check("lost_at", at, exp_q.pop_front());
    check("lost_sys_rst", bus.sys_rst, 1);
    check("lost_ready", bus.ready, 0);
    check("lost_pll_rst", bus.pll_rst, 1);
    check("lost_count", bus.loss_count, exp_count);
    tick(1);
    check("lost_pulse_width", bus.lock_lost, 0);
    check("lost_pll_rst_2", bus.pll_rst, 1);
    tick(2);
    check("lost_pll_rst_end", bus.pll_rst, 0);
    wait_for(0, 40, at);
    check("reacquire_at", at, exp_q.pop_front());
    check("reacquire_ready", bus.ready, 1);
  endtask

  initial begin
    int at;
    int to_base;
    bus.locked_async = 1'b0;

    // 1: clean acquire
    apply_reset();
    check_reset_values("rst");
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      check("t1_pll_rst_window", bus.pll_rst, (k < 3) ? 1 : 0);
    end
    tick(1);
    bus.locked_async = 1'b1;
    exp_q.push_back(cyc + 15);
    wait_for(0, 40, at);
    check("t1_release_at", at, exp_q.pop_front());
    check("t1_ready", bus.ready, 1);
    check("t1_pll_rst", bus.pll_rst, 0);

    // 2: short glitch, then permanent lock
    apply_reset();
    tick(5);
    bus.locked_async = 1'b1;
    tick(5);
    bus.locked_async = 1'b0;
    tick(3);
    bus.locked_async = 1'b1;
    exp_q.push_back(cyc + 15);
    wait_for(0, 40, at);
    check("t2_release_at", at, exp_q.pop_front());
    check("t2_loss_count", bus.loss_count, 0);

    // 3: no lock, repeated timeouts
    apply_reset();
    for (int p = 0; p < 3; p++) exp_q.push_back(e0 + 67 + 67 * p);
    for (int p = 0; p < 3; p++) begin
      wait_for(1, 100, at);
      check("t3_timeout_at", at, exp_q.pop_front());
      check("t3_pll_rst_0", bus.pll_rst, 1);
      check("t3_sys_rst", bus.sys_rst, 1);
      tick(1);
      check("t3_timeout_width", bus.timeout, 0);
      check("t3_pll_rst_1", bus.pll_rst, 1);
      tick(1);
      check("t3_pll_rst_2", bus.pll_rst, 1);
      tick(1);
      check("t3_pll_rst_end", bus.pll_rst, 0);
    end

    // Lock arrives on the cycle the timeout counter expires: lock wins
    apply_reset();
    to_base = n_timeout;
    tick(64);
    bus.locked_async = 1'b1;
    exp_q.push_back(e0 + 79);
    wait_for(0, 40, at);
    check("tb_lock_wins_release_at", at, exp_q.pop_front());
    check("tb_lock_wins_no_timeout", n_timeout - to_base, 0);

    // 4 and 5: lock losses in RUN, count saturates at 3
    lose_lock(1);
    lose_lock(2);
    lose_lock(3);
    lose_lock(3);
    lose_lock(3);

    // Reset in RUN
    rst = 1'b1;
    tick(1);
    check_reset_values("rst_in_run");
    rst = 1'b0;
    tick(2);

    check("lost_timeout_exclusive", n_both, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
